// File: rtl/alu4_seq_pkg.sv
// rtl/alu4_seq_pkg.sv - shared types and constants for the nibble-serial ALU sequencer
package alu4_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIB_DEFAULT = 4;

   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

   // Index counter must be at least one bit even for a single-nibble word.
   function automatic int idx_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/alu4_seq_ctrl_if.sv
// rtl/alu4_seq_ctrl_if.sv - request/response and slice-side signals of the sequencer
interface alu4_seq_ctrl_if
   import alu4_seq_pkg::*;
#(
   parameter int NIB = NIB_DEFAULT
) ();

   logic              req_valid;
   logic              req_ready;
   logic [4*NIB-1:0]  req_a;
   logic [4*NIB-1:0]  req_b;
   logic [3:0]        req_sel;
   logic              req_mode;
   logic              req_cin;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [4*NIB-1:0]  rsp_f;
   logic              rsp_cout;
   logic              rsp_eq;
   logic              rsp_zero;

   logic [3:0]        slc_a;
   logic [3:0]        slc_b;
   logic [3:0]        slc_sel;
   logic              slc_mode;
   logic              slc_cin;
   logic [3:0]        slc_f;
   logic              slc_cout;
   logic              slc_eq;

   modport slave (
      input  req_valid, req_a, req_b, req_sel, req_mode, req_cin,
      output req_ready,
      output rsp_valid, rsp_f, rsp_cout, rsp_eq, rsp_zero,
      input  rsp_ready,
      output slc_a, slc_b, slc_sel, slc_mode, slc_cin,
      input  slc_f, slc_cout, slc_eq
   );

   modport master (
      output req_valid, req_a, req_b, req_sel, req_mode, req_cin,
      input  req_ready,
      input  rsp_valid, rsp_f, rsp_cout, rsp_eq, rsp_zero,
      output rsp_ready,
      input  slc_a, slc_b, slc_sel, slc_mode, slc_cin,
      output slc_f, slc_cout, slc_eq
   );

endinterface

// File: rtl/alu4_seq_dp.sv
// rtl/alu4_seq_dp.sv - operand/result registers, nibble mux, eq accumulator and carry register
module alu4_seq_dp
   import alu4_seq_pkg::*;
#(
   parameter int NIB = NIB_DEFAULT,
   parameter int IW  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_run,
   input  logic [IW-1:0]    i_idx,
   input  logic [4*NIB-1:0] i_a,
   input  logic [4*NIB-1:0] i_b,
   input  logic [3:0]       i_sel,
   input  logic             i_mode,
   input  logic             i_cin,
   input  logic [3:0]       i_slc_f,
   input  logic             i_slc_cout,
   input  logic             i_slc_eq,
   output logic [3:0]       o_slc_a,
   output logic [3:0]       o_slc_b,
   output logic [3:0]       o_slc_sel,
   output logic             o_slc_mode,
   output logic             o_slc_cin,
   output logic [4*NIB-1:0] o_f,
   output logic             o_cout,
   output logic             o_eq,
   output logic             o_zero
);

   logic [4*NIB-1:0] r_a;
   logic [4*NIB-1:0] r_b;
   logic [4*NIB-1:0] r_f;
   logic [3:0]       r_sel;
   logic             r_mode;
   logic             r_carry;
   logic             r_eq;

   logic [3:0]       w_na;
   logic [3:0]       w_nb;

   always_comb begin
      w_na = '0;
      w_nb = '0;
      for (int n = 0; n < NIB; n++) begin
         if (i_idx == n[IW-1:0]) begin
            w_na = r_a[4*n +: 4];
            w_nb = r_b[4*n +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_f     <= '0;
         r_sel   <= '0;
         r_mode  <= MODE_ARITH;
         r_carry <= 1'b0;
         r_eq    <= 1'b0;
      end else if (i_load) begin
         r_a     <= i_a;
         r_b     <= i_b;
         r_f     <= '0;
         r_sel   <= i_sel;
         r_mode  <= i_mode;
         r_carry <= i_cin;
         r_eq    <= 1'b1;
      end else if (i_run) begin
         for (int n = 0; n < NIB; n++) begin
            if (i_idx == n[IW-1:0]) begin
               r_f[4*n +: 4] <= i_slc_f;
            end
         end
         r_eq <= r_eq & i_slc_eq;
         // Logic mode leaves the carry untouched so rsp_cout reports the original cin.
         if (r_mode == MODE_ARITH) begin
            r_carry <= i_slc_cout;
         end
      end
   end

   assign o_slc_a    = i_run ? w_na    : 4'h0;
   assign o_slc_b    = i_run ? w_nb    : 4'h0;
   assign o_slc_sel  = i_run ? r_sel   : 4'h0;
   assign o_slc_mode = i_run ? r_mode  : 1'b0;
   assign o_slc_cin  = i_run ? r_carry : 1'b0;

   assign o_f    = r_f;
   assign o_cout = r_carry;
   assign o_eq   = r_eq;
   assign o_zero = (r_f == '0);

endmodule

// File: rtl/alu4_seq_ctrl.sv
// rtl/alu4_seq_ctrl.sv - nibble-serial sequencer top: FSM, handshakes and nibble index
module alu4_seq_ctrl
   import alu4_seq_pkg::*;
#(
   parameter int NIB = NIB_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   alu4_seq_ctrl_if.slave  bus
);

   localparam int IW = idx_width(NIB);

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_idx;
   logic            w_accept;
   logic            w_run;
   logic            w_last;

   assign w_accept = (r_state == IDLE) && bus.req_valid;
   assign w_run    = (r_state == RUN);
   assign w_last   = (r_idx == IW'(NIB - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.req_valid) w_next = RUN;
         RUN:     if (w_last)        w_next = DONE;
         DONE:    if (bus.rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (w_accept) begin
         r_idx <= '0;
      end else if (w_run) begin
         r_idx <= w_last ? '0 : r_idx + IW'(1);
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == DONE);

   alu4_seq_dp #(
      .NIB (NIB),
      .IW  (IW)
   ) u_dp (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_run      (w_run),
      .i_idx      (r_idx),
      .i_a        (bus.req_a),
      .i_b        (bus.req_b),
      .i_sel      (bus.req_sel),
      .i_mode     (bus.req_mode),
      .i_cin      (bus.req_cin),
      .i_slc_f    (bus.slc_f),
      .i_slc_cout (bus.slc_cout),
      .i_slc_eq   (bus.slc_eq),
      .o_slc_a    (bus.slc_a),
      .o_slc_b    (bus.slc_b),
      .o_slc_sel  (bus.slc_sel),
      .o_slc_mode (bus.slc_mode),
      .o_slc_cin  (bus.slc_cin),
      .o_f        (bus.rsp_f),
      .o_cout     (bus.rsp_cout),
      .o_eq       (bus.rsp_eq),
      .o_zero     (bus.rsp_zero)
   );

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// tb/tb_alu4_seq_ctrl.sv - scoreboard bench for alu4_seq_ctrl with a behavioural slice model
module tb_alu4_seq_ctrl;
   import alu4_seq_pkg::*;

   typedef struct packed {
      logic [15:0] f;
      logic        cout;
      logic        eq;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu4_seq_ctrl_if #(.NIB(4)) if4 ();
   alu4_seq_ctrl_if #(.NIB(1)) if1 ();

   alu4_seq_ctrl #(.NIB(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   alu4_seq_ctrl #(.NIB(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   // Slice model: add with carry in arithmetic mode, xor in logic mode.
   logic [4:0] sum4, sum1;
   assign sum4         = {1'b0, if4.slc_a} + {1'b0, if4.slc_b} + {4'b0, if4.slc_cin};
   assign if4.slc_f    = if4.slc_mode ? (if4.slc_a ^ if4.slc_b) : sum4[3:0];
   assign if4.slc_cout = if4.slc_mode ? 1'b0 : sum4[4];
   assign if4.slc_eq   = (if4.slc_a == if4.slc_b);
   assign sum1         = {1'b0, if1.slc_a} + {1'b0, if1.slc_b} + {4'b0, if1.slc_cin};
   assign if1.slc_f    = if1.slc_mode ? (if1.slc_a ^ if1.slc_b) : sum1[3:0];
   assign if1.slc_cout = if1.slc_mode ? 1'b0 : sum1[4];
   assign if1.slc_eq   = (if1.slc_a == if1.slc_b);

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   logic cin_obs [4];
   int   lat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic mode, input logic cin);
      exp_t       e;
      logic       c;
      logic [4:0] s;
      logic [3:0] na, nb;
      c = cin;
      e.f = '0;
      e.eq = 1'b1;
      for (int n = 0; n < 4; n++) begin
         na = a[4*n +: 4];
         nb = b[4*n +: 4];
         s = {1'b0, na} + {1'b0, nb} + {4'b0, c};
         if (mode == MODE_ARITH) begin
            e.f[4*n +: 4] = s[3:0];
            c = s[4];
         end else begin
            e.f[4*n +: 4] = na ^ nb;
         end
         e.eq = e.eq & (na == nb);
      end
      e.cout = c;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic mode,
                         input logic cin, input bit keep, input bit push);
      int n;
      if (push) sb.push_back(model(a, b, mode, cin));
      if4.req_a     = a;
      if4.req_b     = b;
      if4.req_sel   = 4'h9;
      if4.req_mode  = mode;
      if4.req_cin   = cin;
      if4.req_valid = 1'b1;
      n = 0;
      while (!if4.req_ready && n < 50) begin
         tick();
         n++;
      end
      chk("accept_wait", n < 50, 1);
      tick();
      if (!keep) if4.req_valid = 1'b0;
   endtask

   task automatic wait_rsp4();
      lat = 0;
      while (!if4.rsp_valid && lat < 50) begin
         if (lat < 4) cin_obs[lat] = if4.slc_cin;
         tick();
         lat++;
      end
   endtask

   task automatic collect4();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("rsp_f", if4.rsp_f, e.f);
         chk("rsp_cout", if4.rsp_cout, e.cout);
         chk("rsp_eq", if4.rsp_eq, e.eq);
         chk("rsp_zero", if4.rsp_zero, e.f == 16'h0);
      end
      if4.rsp_ready = 1'b1;
      tick();
      if4.rsp_ready = 1'b0;
      chk("rsp_valid_drop", if4.rsp_valid, 0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rm, rc;
      if4.req_valid = 0; if4.req_a = 0; if4.req_b = 0; if4.req_sel = 0;
      if4.req_mode = 0;  if4.req_cin = 0; if4.rsp_ready = 0;
      if1.req_valid = 0; if1.req_a = 0; if1.req_b = 0; if1.req_sel = 0;
      if1.req_mode = 0;  if1.req_cin = 0; if1.rsp_ready = 0;

      repeat (2) tick();
      chk("rst_req_ready", if4.req_ready, 1);
      chk("rst_rsp_valid", if4.rsp_valid, 0);
      chk("rst_rsp_f", if4.rsp_f, 0);
      chk("rst_rsp_cout", if4.rsp_cout, 0);
      chk("rst_rsp_eq", if4.rsp_eq, 0);
      chk("rst_rsp_zero", if4.rsp_zero, 1);
      chk("rst_slc", {if4.slc_a, if4.slc_b, if4.slc_sel, if4.slc_mode, if4.slc_cin}, 0);
      rst_n = 1'b1;
      tick();

      start4(16'h1234, 16'h0FFF, MODE_ARITH, 1'b0, 0, 1);
      wait_rsp4();
      chk("t1_latency", lat, 4);
      chk("t1_f", if4.rsp_f, 16'h2233);
      chk("t1_cout", if4.rsp_cout, 0);
      chk("t1_zero", if4.rsp_zero, 0);
      collect4();

      start4(16'hFFFF, 16'h0001, MODE_ARITH, 1'b0, 0, 1);
      wait_rsp4();
      chk("t2_cin_seq", {cin_obs[0], cin_obs[1], cin_obs[2], cin_obs[3]}, 4'b0111);
      chk("t2_f", if4.rsp_f, 16'h0000);
      chk("t2_cout", if4.rsp_cout, 1);
      chk("t2_zero", if4.rsp_zero, 1);
      collect4();

      start4(16'hA5A5, 16'hA5A5, MODE_LOGIC, 1'b1, 0, 1);
      wait_rsp4();
      chk("t3_f", if4.rsp_f, 16'h0000);
      chk("t3_eq", if4.rsp_eq, 1);
      chk("t3_zero", if4.rsp_zero, 1);
      chk("t3_cout", if4.rsp_cout, 1);
      collect4();

      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom);
         rb = (i == 2) ? ra : 16'($urandom);
         rm = 1'($urandom);
         rc = 1'($urandom);
         start4(ra, rb, rm, rc, 0, 1);
         wait_rsp4();
         chk("rand_latency", lat, 4);
         collect4();
      end

      // Backpressure: result held while a second request waits.
      start4(16'h00F0, 16'h0F0F, MODE_ARITH, 1'b0, 1, 1);
      sb.push_back(model(16'h00F0, 16'h0F0F, MODE_ARITH, 1'b0));
      wait_rsp4();
      chk("bp_latency", lat, 4);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", if4.rsp_valid, 1);
         chk("bp_req_ready", if4.req_ready, 0);
         chk("bp_rsp_f", if4.rsp_f, 16'h0FFF);
         tick();
      end
      collect4();
      chk("bp_ready_after_hs", if4.req_ready, 1);
      tick();
      if4.req_valid = 1'b0;
      chk("bp_accepted", if4.req_ready, 0);
      wait_rsp4();
      chk("bp2_latency", lat, 4);
      collect4();

      // Reset in the middle of an operation.
      start4(16'h1111, 16'h2222, MODE_ARITH, 1'b0, 0, 0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", if4.req_ready, 1);
      chk("mid_rst_rsp_valid", if4.rsp_valid, 0);
      chk("mid_rst_rsp_f", if4.rsp_f, 0);
      chk("mid_rst_cout_eq", {if4.rsp_cout, if4.rsp_eq}, 0);
      chk("mid_rst_zero", if4.rsp_zero, 1);
      chk("mid_rst_slc", {if4.slc_a, if4.slc_b, if4.slc_sel, if4.slc_mode, if4.slc_cin}, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_no_rsp", if4.rsp_valid, 0);
      end
      start4(16'h0001, 16'h0001, MODE_ARITH, 1'b0, 0, 1);
      wait_rsp4();
      chk("post_rst_f", if4.rsp_f, 16'h0002);
      collect4();

      // Single-nibble instance.
      if1.req_a = 4'h9; if1.req_b = 4'h8; if1.req_mode = MODE_ARITH;
      if1.req_cin = 1'b0; if1.req_sel = 4'h3; if1.req_valid = 1'b1;
      chk("n1_req_ready", if1.req_ready, 1);
      tick();
      if1.req_valid = 1'b0;
      chk("n1_run_no_valid", if1.rsp_valid, 0);
      tick();
      chk("n1_rsp_valid", if1.rsp_valid, 1);
      chk("n1_f", if1.rsp_f, 4'h1);
      chk("n1_cout", if1.rsp_cout, 1);
      chk("n1_zero", if1.rsp_zero, 0);
      if1.rsp_ready = 1'b1;
      tick();
      if1.rsp_ready = 1'b0;
      chk("n1_rsp_drop", if1.rsp_valid, 0);

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
